// File: rtl/multicycle_ctrl_pkg.sv
// Shared state encoding and constants for the multi-cycle sequencer.
package multicycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6,
        ST_TRAP   = 3'd7
    } state_t;

    // addi x0,x0,0 -- IR contents after reset
    localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

endpackage

// File: rtl/multicycle_ctrl_pc_unit.sv
// PC register, pc+4 adder, next-PC mux and redirect-target alignment check.
import multicycle_ctrl_pkg::*;

module pc_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        wb_en,
    input  logic        dec_branch,
    input  logic        dec_jump,
    input  logic        branch_taken,
    input  logic [31:0] target_addr,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        misaligned
);

    logic        redirect;
    logic [31:0] pc_next;

    // Redirect select and misalignment flag; wraps naturally at 2^32.
    always_comb begin
        redirect   = dec_jump | (dec_branch & branch_taken);
        misaligned = redirect & (target_addr[1:0] != 2'b00);
        pc_plus4   = pc + 32'd4;
        pc_next    = redirect ? target_addr : pc_plus4;
    end

    // PC only moves in WB, and never toward a misaligned target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            pc <= RESET_PC;
        else if (wb_en && !misaligned)
            pc <= pc_next;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle sequencer: owns PC and IR, steps FETCH/DECODE/EXEC/MEM/WB.
import multicycle_ctrl_pkg::*;

module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ready,
    output logic [31:0] instr,
    input  logic        dec_reg_write,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_branch,
    input  logic        dec_jump,
    input  logic        dec_is_system,
    input  logic        branch_taken,
    input  logic [31:0] target_addr,
    output logic        dmem_req,
    output logic        dmem_we,
    input  logic        dmem_ready,
    output logic        rf_we,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        halted,
    output logic        trap,
    output logic [31:0] retired
);

    state_t      state_q, state_d;
    logic [31:0] ir_q;
    logic [31:0] retired_q;
    logic        misaligned;
    logic        in_wb;
    logic        wb_ok;

    pc_unit #(.RESET_PC(RESET_PC)) u_pc (
        .clk          (clk),
        .rst_n        (rst_n),
        .wb_en        (in_wb),
        .dec_branch   (dec_branch),
        .dec_jump     (dec_jump),
        .branch_taken (branch_taken),
        .target_addr  (target_addr),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
        .misaligned   (misaligned)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    // Next-state and Moore output decode; ready inputs only steer state_d.
    always_comb begin
        state_d  = state_q;
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        halted   = 1'b0;
        trap     = 1'b0;
        in_wb    = 1'b0;
        wb_ok    = 1'b0;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) state_d = ST_DECODE;
            end
            ST_DECODE: state_d = dec_is_system ? ST_HALT : ST_EXEC;
            ST_EXEC:   state_d = (dec_mem_read || dec_mem_write) ? ST_MEM : ST_WB;
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = dec_mem_write;
                if (dmem_ready) state_d = ST_WB;
            end
            ST_WB: begin
                in_wb   = 1'b1;
                wb_ok   = !misaligned;
                rf_we   = dec_reg_write && !misaligned;
                state_d = misaligned ? ST_TRAP : ST_FETCH;
            end
            ST_HALT:   halted = 1'b1;
            ST_TRAP:   trap   = 1'b1;
            default:   state_d = ST_IDLE;
        endcase
    end

    // IR captures only on the fetch-completion edge so decode stays stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ir_q <= INSTR_NOP;
        else if (state_q == ST_FETCH && imem_ready)
            ir_q <= imem_rdata;
    end

    // Retired count bumps once per successful WB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            retired_q <= 32'd0;
        else if (wb_ok)
            retired_q <= retired_q + 32'd1;
    end

    assign imem_addr = pc;
    assign instr     = ir_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl; the bench plays decoder_glue and both memories.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'd0;
    logic        imem_ready = 1'b0;
    logic [31:0] instr;
    logic        dec_reg_write = 1'b0, dec_mem_read = 1'b0, dec_mem_write = 1'b0;
    logic        dec_branch = 1'b0, dec_jump = 1'b0, dec_is_system = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] target_addr = 32'd0;
    logic        dmem_req, dmem_we;
    logic        dmem_ready = 1'b0;
    logic        rf_we;
    logic [31:0] pc, pc_plus4;
    logic        halted, trap;
    logic [31:0] retired;

    int n_vec = 0;
    int n_err = 0;
    int r_cycles, r_rf, r_dreq, r_we;
    logic r_to;

    multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ready(imem_ready),
        .instr(instr),
        .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_branch(dec_branch), .dec_jump(dec_jump), .dec_is_system(dec_is_system),
        .branch_taken(branch_taken), .target_addr(target_addr),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
        .rf_we(rf_we), .pc(pc), .pc_plus4(pc_plus4),
        .halted(halted), .trap(trap), .retired(retired)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Runs one instruction starting in FETCH; stops at next FETCH, HALT or TRAP.
    task automatic run_instr(input logic [31:0] word, input logic rw, input logic mr,
                             input logic mw, input logic br, input logic jp, input logic sys,
                             input logic bt, input logic [31:0] tgt, input int wait_cyc);
        imem_rdata = word; imem_ready = 1'b1;
        dec_reg_write = rw; dec_mem_read = mr; dec_mem_write = mw;
        dec_branch = br; dec_jump = jp; dec_is_system = sys;
        branch_taken = bt; target_addr = tgt; dmem_ready = 1'b0;
        r_cycles = 0; r_rf = 0; r_dreq = 0; r_we = 0;
        do begin
            if (rf_we) r_rf++;
            if (dmem_req) begin
                r_dreq++;
                if (dmem_we) r_we++;
                dmem_ready = (r_dreq > wait_cyc);
            end else begin
                dmem_ready = 1'b0;
            end
            step();
            r_cycles++;
            imem_ready = 1'b0;
        end while (!(imem_req || halted || trap) && r_cycles < 50);
        dmem_ready = 1'b0;
        r_to = (r_cycles >= 50);
    endtask

    task automatic test_reset();
        step(); step();
        n_vec++; if (imem_req !== 1'b0 || dmem_req !== 1'b0 || dmem_we !== 1'b0 || rf_we !== 1'b0) begin
            n_err++; $display("FAIL reset_strobes: imem=%b dmem=%b we=%b rf=%b required 0", imem_req, dmem_req, dmem_we, rf_we); end
        n_vec++; if (halted !== 1'b0 || trap !== 1'b0) begin
            n_err++; $display("FAIL reset_stop: halted=%b trap=%b required 0", halted, trap); end
        n_vec++; if (pc !== 32'd0 || retired !== 32'd0 || instr !== 32'h13) begin
            n_err++; $display("FAIL reset_regs: pc=%h retired=%0d instr=%h required 0/0/00000013", pc, retired, instr); end
        rst_n = 1'b1;
        // cycle 1 after release is IDLE
        n_vec++; if (imem_req !== 1'b0) begin
            n_err++; $display("FAIL idle_cycle1: imem_req=%b required 0", imem_req); end
        step();
        n_vec++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin
            n_err++; $display("FAIL fetch_cycle2: imem_req=%b addr=%h required 1/0", imem_req, imem_addr); end
    endtask

    task automatic test_alu();
        // addi x6,x1,0x7F
        run_instr(32'h07F08313, 1, 0, 0, 0, 0, 0, 0, 32'd0, 0);
        n_vec++; if (r_to || r_cycles !== 4) begin
            n_err++; $display("FAIL alu_cycles: got %0d required 4", r_cycles); end
        n_vec++; if (r_rf !== 1 || r_dreq !== 0) begin
            n_err++; $display("FAIL alu_strobes: rf=%0d dreq=%0d required 1/0", r_rf, r_dreq); end
        n_vec++; if (pc !== 32'd4 || retired !== 32'd1 || instr !== 32'h07F08313) begin
            n_err++; $display("FAIL alu_state: pc=%h retired=%0d instr=%h required 4/1/07f08313", pc, retired, instr); end
    endtask

    task automatic test_load();
        // lw x7,24(x3), data ready after 3 wait cycles
        run_instr(32'h0181A383, 1, 1, 0, 0, 0, 0, 0, 32'd0, 3);
        n_vec++; if (r_dreq !== 4 || r_we !== 0) begin
            n_err++; $display("FAIL load_mem: dreq=%0d we=%0d required 4/0", r_dreq, r_we); end
        n_vec++; if (r_rf !== 1) begin
            n_err++; $display("FAIL load_rf: got %0d required 1", r_rf); end
        n_vec++; if (r_to || r_cycles !== 8) begin
            n_err++; $display("FAIL load_cycles: got %0d required 8", r_cycles); end
        n_vec++; if (pc !== 32'd8 || retired !== 32'd2) begin
            n_err++; $display("FAIL load_pc: pc=%h retired=%0d required 8/2", pc, retired); end
    endtask

    task automatic test_store();
        // sw x8,28(x4)
        run_instr(32'h00822E23, 0, 0, 1, 0, 0, 0, 0, 32'd0, 0);
        n_vec++; if (r_dreq !== 1 || r_we !== 1) begin
            n_err++; $display("FAIL store_mem: dreq=%0d we=%0d required 1/1", r_dreq, r_we); end
        n_vec++; if (r_rf !== 0 || r_cycles !== 5) begin
            n_err++; $display("FAIL store_rf_cycles: rf=%0d cycles=%0d required 0/5", r_rf, r_cycles); end
        n_vec++; if (pc !== 32'd12 || retired !== 32'd3) begin
            n_err++; $display("FAIL store_pc: pc=%h retired=%0d required c/3", pc, retired); end
    endtask

    task automatic test_branch();
        // beq taken: pc 12 -> 28
        run_instr(32'h00208863, 0, 0, 0, 1, 0, 0, 1, 32'd28, 0);
        n_vec++; if (pc !== 32'd28 || r_rf !== 0 || r_cycles !== 4) begin
            n_err++; $display("FAIL beq_taken: pc=%h rf=%0d cycles=%0d required 1c/0/4", pc, r_rf, r_cycles); end
        // beq not taken: pc 28 -> 32
        run_instr(32'h00208863, 0, 0, 0, 1, 0, 0, 0, 32'd44, 0);
        n_vec++; if (pc !== 32'd32 || r_rf !== 0 || retired !== 32'd5) begin
            n_err++; $display("FAIL beq_not_taken: pc=%h rf=%0d retired=%0d required 20/0/5", pc, r_rf, retired); end
    endtask

    task automatic test_pc_wrap();
        // jal to the top word, then two ALU ops wrap pc through zero
        run_instr(32'h0000006F, 1, 0, 0, 0, 1, 0, 0, 32'hFFFF_FFFC, 0);
        n_vec++; if (pc !== 32'hFFFF_FFFC || pc_plus4 !== 32'd0 || r_rf !== 1) begin
            n_err++; $display("FAIL wrap_jal: pc=%h pc4=%h rf=%0d required fffffffc/0/1", pc, pc_plus4, r_rf); end
        run_instr(32'h07F08313, 1, 0, 0, 0, 0, 0, 0, 32'd0, 0);
        n_vec++; if (pc !== 32'd0 || retired !== 32'd7) begin
            n_err++; $display("FAIL wrap_pc: pc=%h retired=%0d required 0/7", pc, retired); end
        run_instr(32'h07F08313, 1, 0, 0, 0, 0, 0, 0, 32'd0, 0);
        n_vec++; if (pc !== 32'd4 || retired !== 32'd8) begin
            n_err++; $display("FAIL wrap_next: pc=%h retired=%0d required 4/8", pc, retired); end
    endtask

    task automatic test_misaligned_trap();
        int reqs;
        run_instr(32'h0220006F, 1, 0, 0, 0, 1, 0, 0, 32'h0000_0022, 0);
        n_vec++; if (trap !== 1'b1 || halted !== 1'b0 || r_to) begin
            n_err++; $display("FAIL trap_flag: trap=%b halted=%b required 1/0", trap, halted); end
        n_vec++; if (pc !== 32'd4 || retired !== 32'd8 || r_rf !== 0) begin
            n_err++; $display("FAIL trap_state: pc=%h retired=%0d rf=%0d required 4/8/0", pc, retired, r_rf); end
        reqs = 0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (imem_req || dmem_req || !trap) reqs++;
        end
        n_vec++; if (reqs !== 0) begin
            n_err++; $display("FAIL trap_hold: %0d bad cycles required 0", reqs); end
    endtask

    task automatic test_reset_mid_mem();
        int reqs;
        rst_n = 1'b0; step(); rst_n = 1'b1;
        step();
        // lw with dmem never ready
        imem_rdata = 32'h0181A383; imem_ready = 1'b1;
        dec_reg_write = 1; dec_mem_read = 1; dec_mem_write = 0;
        dec_branch = 0; dec_jump = 0; dec_is_system = 0; dmem_ready = 1'b0;
        step(); imem_ready = 1'b0;
        step(); step(); step();
        n_vec++; if (dmem_req !== 1'b1) begin
            n_err++; $display("FAIL midmem_enter: dmem_req=%b required 1", dmem_req); end
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if (dmem_req !== 1'b0 || imem_req !== 1'b0 || rf_we !== 1'b0) begin
            n_err++; $display("FAIL midmem_drop: dmem=%b imem=%b rf=%b required 0", dmem_req, imem_req, rf_we); end
        n_vec++; if (pc !== 32'd0 || retired !== 32'd0 || instr !== 32'h13 || trap !== 1'b0) begin
            n_err++; $display("FAIL midmem_regs: pc=%h ret=%0d instr=%h trap=%b required 0/0/13/0", pc, retired, instr, trap); end
        @(posedge clk); #1 rst_n = 1'b1;
        step();
        n_vec++; if (imem_req !== 1'b1) begin
            n_err++; $display("FAIL midmem_refetch: imem_req=%b required 1", imem_req); end
        // ecall
        run_instr(32'h00000073, 0, 0, 0, 0, 0, 1, 0, 32'd0, 0);
        n_vec++; if (halted !== 1'b1 || trap !== 1'b0 || r_cycles !== 2) begin
            n_err++; $display("FAIL ecall_halt: halted=%b trap=%b cycles=%0d required 1/0/2", halted, trap, r_cycles); end
        reqs = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (imem_req || dmem_req || rf_we || !halted) reqs++;
        end
        n_vec++; if (reqs !== 0 || retired !== 32'd0) begin
            n_err++; $display("FAIL halt_hold: bad=%0d retired=%0d required 0/0", reqs, retired); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_branch();
        test_pc_wrap();
        test_misaligned_trap();
        test_reset_mid_mem();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
